// File: rtl/io_tick_scheduler.sv
// io_tick_scheduler
//   A shared free-running prescaler produces a base tick every PRESCALE clocks. CHANNELS
//   independent counters divide that base tick by software-set periods. Each channel drives
//   a registered one-cycle tick pulse and a sticky flag. An interrupt is raised from the
//   enabled flags.
//
// Ports
//   clk       system clock
//   rst_n     synchronous active-low reset
//   we        register write strobe
//   addr      word address: 2i = PERIOD[i], 2i+1 = CTRL[i] {ie, oneshot, en}, 2*CHANNELS = STATUS
//   wdata     write data
//   rdata     combinational read data for addr
//   tick_out  per-channel one-cycle tick pulse, registered
//   irq       registered OR of (flag & ie)
module io_tick_scheduler #(
    parameter int unsigned PRESCALE = 50000,
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned CNT_W    = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                we,
    input  logic [4:0]          addr,
    input  logic [31:0]         wdata,
    output logic [31:0]         rdata,
    output logic [CHANNELS-1:0] tick_out,
    output logic                irq
);

    localparam int unsigned     PW         = $clog2(PRESCALE);
    localparam logic [PW-1:0]   PresLast   = PW'(PRESCALE - 1);
    localparam logic [4:0]      StatusAddr = 5'(2 * CHANNELS);

    logic [PW-1:0]       presc_q;
    logic                base_tick;

    logic [CNT_W-1:0]    period_q [CHANNELS];
    logic [CNT_W-1:0]    period_d [CHANNELS];
    logic [CNT_W-1:0]    cnt_q    [CHANNELS];
    logic [CNT_W-1:0]    cnt_d    [CHANNELS];
    logic [CHANNELS-1:0] en_q, en_d;
    logic [CHANNELS-1:0] os_q, os_d;
    logic [CHANNELS-1:0] ie_q, ie_d;
    logic [CHANNELS-1:0] flag_q, flag_d;
    logic [CHANNELS-1:0] tick_q;
    logic                irq_q;

    logic [CHANNELS-1:0] fire;
    logic [CHANNELS-1:0] period_we;
    logic [CHANNELS-1:0] ctrl_we;
    logic                status_we;

    assign base_tick = (presc_q == PresLast);

    // Register write decode
    always_comb begin
        period_we = '0;
        ctrl_we   = '0;
        for (int i = 0; i < int'(CHANNELS); i++) begin
            period_we[i] = we && (addr == 5'(2 * i));
            ctrl_we[i]   = we && (addr == 5'(2 * i + 1));
        end
        status_we = we && (addr == StatusAddr);
    end

    // Channel next state
    always_comb begin
        period_d = period_q;
        cnt_d    = cnt_q;
        en_d     = en_q;
        os_d     = os_q;
        ie_d     = ie_q;
        fire     = '0;
        for (int i = 0; i < int'(CHANNELS); i++) begin
            // PERIOD-1 is only meaningful when PERIOD != 0, so the zero check guards the wrap
            fire[i] = base_tick && en_q[i] && (period_q[i] != '0) &&
                      (cnt_q[i] == period_q[i] - 1'b1);

            if (!en_q[i]) begin
                cnt_d[i] = '0;
            end else if (base_tick) begin
                if ((period_q[i] == '0) || fire[i]) begin
                    cnt_d[i] = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end

            if (fire[i] && os_q[i]) begin
                en_d[i] = 1'b0;
            end
            // A CTRL write overrides a coincident one-shot disable
            if (ctrl_we[i]) begin
                en_d[i] = wdata[0];
                os_d[i] = wdata[1];
                ie_d[i] = wdata[2];
            end
            if (period_we[i]) begin
                period_d[i] = CNT_W'(wdata);
            end

            if (period_we[i] || !en_d[i] || (ctrl_we[i] && wdata[0] && !en_q[i])) begin
                cnt_d[i] = '0;
            end
        end
    end

    // Fire sets after the clear so a coincident STATUS write cannot lose an event
    always_comb begin
        flag_d = flag_q;
        if (status_we) begin
            flag_d = flag_d & ~wdata[CHANNELS-1:0];
        end
        flag_d = flag_d | fire;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc_q  <= '0;
            for (int i = 0; i < int'(CHANNELS); i++) begin
                period_q[i] <= '0;
                cnt_q[i]    <= '0;
            end
            en_q     <= '0;
            os_q     <= '0;
            ie_q     <= '0;
            flag_q   <= '0;
            tick_q   <= '0;
            irq_q    <= 1'b0;
        end else begin
            presc_q  <= base_tick ? '0 : presc_q + 1'b1;
            period_q <= period_d;
            cnt_q    <= cnt_d;
            en_q     <= en_d;
            os_q     <= os_d;
            ie_q     <= ie_d;
            flag_q   <= flag_d;
            tick_q   <= fire;
            irq_q    <= |(flag_q & ie_q);
        end
    end

    // Read mux
    always_comb begin
        rdata = '0;
        for (int i = 0; i < int'(CHANNELS); i++) begin
            if (addr == 5'(2 * i)) begin
                rdata = 32'(period_q[i]);
            end
            if (addr == 5'(2 * i + 1)) begin
                rdata = {29'd0, ie_q[i], os_q[i], en_q[i]};
            end
        end
        if (addr == StatusAddr) begin
            rdata = 32'(flag_q);
        end
    end

    assign tick_out = tick_q;
    assign irq      = irq_q;

endmodule

// File: tb/tb_io_tick_scheduler.sv
// tb_io_tick_scheduler
//   Directed bench for io_tick_scheduler with PRESCALE=4, CHANNELS=4. Expected tick pulses
//   are predicted from a prescaler phase model and queued as (cycle*8 + channel); a monitor
//   pops and compares every observed pulse.
module tb_io_tick_scheduler;

    localparam int P   = 4;
    localparam int NCH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        we = 1'b0;
    logic [4:0]  addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic [3:0]  tick_out;
    logic        irq;

    io_tick_scheduler #(
        .PRESCALE (P),
        .CHANNELS (NCH),
        .CNT_W    (32)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .we       (we),
        .addr     (addr),
        .wdata    (wdata),
        .rdata    (rdata),
        .tick_out (tick_out),
        .irq      (irq)
    );

    always #10 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int rel_edge = 0;
    int tests = 0;
    int fails = 0;
    int exp_q[$];
    int pulse_cnt[NCH];

    // Scoreboard: every observed pulse must match the next queued prediction
    always @(negedge clk) begin
        for (int ch = 0; ch < NCH; ch++) begin
            if (tick_out[ch] !== 1'b0) begin
                int obs;
                int exp_v;
                obs   = cyc * 8 + ch;
                exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
                pulse_cnt[ch]++;
                tests++;
                assert (obs === exp_v) else begin
                    fails++;
                    $error("FAIL tick_ch%0d: pulse code %0d (cycle %0d), required %0d",
                           ch, obs, cyc, exp_v);
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: got 0x%0h, required 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    // Write lands on the next posedge; returns that edge's cycle number
    task automatic wr(input logic [4:0] a, input logic [31:0] d, output int wedge);
        we    = 1'b1;
        addr  = a;
        wdata = d;
        step(1);
        we    = 1'b0;
        wedge = cyc;
    endtask

    task automatic rd(input logic [4:0] a, output logic [31:0] d);
        addr = a;
        #1;
        d = rdata;
    endtask

    task automatic wait_cyc(input int target);
        int g;
        g = 0;
        while (cyc < target && g < 5000) begin
            step(1);
            g++;
        end
        check("wait_cycle", 32'(cyc), 32'(target));
    endtask

    task automatic wait_drain(input int budget);
        int g;
        g = 0;
        while (exp_q.size() > 0 && g < budget) begin
            step(1);
            g++;
        end
        check("missing_pulses", 32'(exp_q.size()), 32'd0);
    endtask

    // Edge number at whose following cycle the k-th base tick (k >= 1) at/after edge w occurs
    function automatic int base_edge(input int w, input int k);
        int e1;
        e1 = w + ((3 - ((w - rel_edge) % P)) + P) % P;
        return e1 + P * (k - 1);
    endfunction

    initial begin
        int          w;
        int          f;
        int          base_pc;
        logic [31:0] d;

        // Reset state
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
        rel_edge = cyc;
        check("reset_tick", 32'(tick_out), 32'd0);
        check("reset_irq", 32'(irq), 32'd0);
        for (int a = 0; a <= 8; a++) begin
            rd(5'(a), d);
            check($sformatf("reset_rd%0d", a), d, 32'd0);
            step(1);
        end
        step(200);
        check("reset_quiet", 32'(pulse_cnt[0] + pulse_cnt[1] + pulse_cnt[2] + pulse_cnt[3]),
              32'd0);

        // Periodic channel 0, period 3
        wr(5'd0, 32'd3, w);
        wr(5'd1, 32'h1, w);
        f = base_edge(w, 3) + 1;
        for (int k = 0; k < 3; k++) exp_q.push_back((base_edge(w, 3 + 3 * k) + 1) * 8 + 0);
        wait_cyc(f);
        rd(5'd8, d);
        check("status_after_first", d, 32'h1);
        wait_drain(100);
        wr(5'd1, 32'h0, w);

        // One-shot channel 1 with interrupt
        wr(5'd2, 32'd2, w);
        wr(5'd3, 32'h7, w);
        f = base_edge(w, 2) + 1;
        exp_q.push_back(f * 8 + 1);
        wait_cyc(f);
        check("irq_before_rise", 32'(irq), 32'd0);
        step(1);
        check("irq_rise", 32'(irq), 32'd1);
        step(100);
        check("oneshot_count", 32'(pulse_cnt[1]), 32'd1);
        rd(5'd3, d);
        check("ctrl1_after_oneshot", d, 32'h6);
        wr(5'd8, 32'h2, w);
        check("irq_hold", 32'(irq), 32'd1);
        step(1);
        check("irq_fall", 32'(irq), 32'd0);
        rd(5'd8, d);
        check("status_flag0_only", d, 32'h1);

        // Period boundaries on channel 2
        wr(5'd4, 32'd0, w);
        wr(5'd5, 32'h1, w);
        base_pc = pulse_cnt[2];
        step(100);
        check("period0_silent", 32'(pulse_cnt[2] - base_pc), 32'd0);
        wr(5'd4, 32'd1, w);
        for (int k = 1; k <= 5; k++) exp_q.push_back((base_edge(w, k) + 1) * 8 + 2);
        wait_drain(100);
        wr(5'd5, 32'h0, w);

        // STATUS clear colliding with a channel 0 fire
        wr(5'd1, 32'h1, w);
        f = base_edge(w, 3) + 1;
        exp_q.push_back(f * 8 + 0);
        wait_cyc(f - 1);
        wr(5'd8, 32'hF, w);
        rd(5'd8, d);
        check("collision_flag0_set", {31'd0, d[0]}, 32'd1);
        wr(5'd8, 32'hF, w);
        rd(5'd8, d);
        check("late_clear_status", d, 32'd0);

        // Reset while channel 0's counter sits at 2 (next fire would be at edge f+12)
        wait_cyc(f + 9);
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
        rel_edge = cyc;
        check("midreset_tick", 32'(tick_out), 32'd0);
        check("midreset_irq", 32'(irq), 32'd0);
        for (int a = 0; a <= 8; a++) begin
            rd(5'(a), d);
            check($sformatf("midreset_rd%0d", a), d, 32'd0);
            step(1);
        end
        base_pc = pulse_cnt[0];
        step(100);
        check("midreset_no_pulse", 32'(pulse_cnt[0] - base_pc), 32'd0);
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
